// File: rtl/ps2_rx_frame_pkg.sv
// ============================================================================
// Module : ps2_rx_frame_pkg
// Brief  : Shared frame geometry, default timing and FSM state encoding for
//          the PS/2 device-to-host receiver.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ps2_rx_frame_pkg;

  localparam int FRAME_BITS      = 11;
  localparam int DATA_BITS       = 8;
  localparam int DEF_FILTER_LEN  = 8;
  localparam int DEF_TIMEOUT_CYC = 5000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DPS  = 2'd1,
    ST_LOAD = 2'd2
  } state_t;

  // Odd parity holds when data plus parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [DATA_BITS:0] bits);
    return ^bits;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_rx_frame_if.sv
// ============================================================================
// Module : ps2_rx_frame_if
// Brief  : PS/2 line inputs, receive enable and received-byte outputs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface ps2_rx_frame_if;
  import ps2_rx_frame_pkg::*;

  logic                 ps2c;
  logic                 ps2d;
  logic                 rx_en;
  logic                 rx_done_tick;
  logic                 rx_err;
  logic [DATA_BITS-1:0] dout;

  modport master (
    output ps2c, ps2d, rx_en,
    input  rx_done_tick, rx_err, dout
  );

  modport slave (
    input  ps2c, ps2d, rx_en,
    output rx_done_tick, rx_err, dout
  );

endinterface

`default_nettype wire

// File: rtl/ps2_rx_frame_clk_filter.sv
// ============================================================================
// Module : ps2_clk_filter
// Brief  : Synchronises ps2c/ps2d, debounces ps2c and flags its falling edge.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_ps2c,
  input  logic i_ps2d,
  output logic o_fall_edge,
  output logic o_ps2d_sync
);

  logic [1:0]            r_c_sync;
  logic [1:0]            r_d_sync;
  logic [FILTER_LEN-1:0] r_filter;
  logic                  r_f_ps2c;
  logic                  r_f_ps2c_prev;

  // Idle PS/2 lines are high, so every stage resets to 1 to avoid a false edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_c_sync      <= 2'b11;
      r_d_sync      <= 2'b11;
      r_filter      <= '1;
      r_f_ps2c      <= 1'b1;
      r_f_ps2c_prev <= 1'b1;
    end else begin
      r_c_sync      <= {r_c_sync[0], i_ps2c};
      r_d_sync      <= {r_d_sync[0], i_ps2d};
      r_filter      <= {r_c_sync[1], r_filter[FILTER_LEN-1:1]};
      if (&r_filter) begin
        r_f_ps2c <= 1'b1;
      end else if (~|r_filter) begin
        r_f_ps2c <= 1'b0;
      end
      r_f_ps2c_prev <= r_f_ps2c;
    end
  end

  assign o_fall_edge = r_f_ps2c_prev & ~r_f_ps2c;
  assign o_ps2d_sync = r_d_sync[1];

endmodule

`default_nettype wire

// File: rtl/ps2_rx_frame.sv
// ============================================================================
// Module : ps2_rx_frame
// Brief  : PS/2 11-bit frame receiver with stop-bit and timeout error flags.
//          Define PS2_PARITY_CHECK_EN to also reject frames with bad parity.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ps2_rx_frame
  import ps2_rx_frame_pkg::*;
#(
  parameter int FILTER_LEN  = DEF_FILTER_LEN,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic           clk,
  input  logic           reset,
  ps2_rx_frame_if.slave  bus
);

  localparam int                c_TO_W    = $clog2(TIMEOUT_CYC);
  localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYC - 1);

  logic w_fall;
  logic w_ps2d;

  ps2_clk_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk         (clk),
    .reset       (reset),
    .i_ps2c      (bus.ps2c),
    .i_ps2d      (bus.ps2d),
    .o_fall_edge (w_fall),
    .o_ps2d_sync (w_ps2d)
  );

  state_t                r_state, w_state_nx;
  logic [3:0]            r_n,     w_n_nx;
  logic [FRAME_BITS-1:0] r_b,     w_b_nx;
  logic [c_TO_W-1:0]     r_to,    w_to_nx;
  logic [DATA_BITS-1:0]  r_dout,  w_dout_nx;
  logic                  w_tick;
  logic                  w_err;
  logic                  w_frame_ok;

`ifdef PS2_PARITY_CHECK_EN
  assign w_frame_ok = ~r_b[0] & r_b[10] & odd_parity_ok(r_b[9:1]);
`else
  assign w_frame_ok = ~r_b[0] & r_b[10];
  logic w_unused_par;
  assign w_unused_par = r_b[9];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_n     <= '0;
      r_b     <= '0;
      r_to    <= '0;
      r_dout  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_n     <= w_n_nx;
      r_b     <= w_b_nx;
      r_to    <= w_to_nx;
      r_dout  <= w_dout_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_n_nx     = r_n;
    w_b_nx     = r_b;
    w_to_nx    = r_to;
    w_dout_nx  = r_dout;
    w_tick     = 1'b0;
    w_err      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_to_nx = '0;
        if (w_fall && bus.rx_en && !w_ps2d) begin
          w_b_nx     = {w_ps2d, r_b[FRAME_BITS-1:1]};
          w_n_nx     = 4'd9;
          w_state_nx = ST_DPS;
        end
      end
      ST_DPS: begin
        // A real edge always wins over a timeout landing in the same cycle.
        if (w_fall) begin
          w_b_nx  = {w_ps2d, r_b[FRAME_BITS-1:1]};
          w_to_nx = '0;
          if (r_n == 4'd0) begin
            w_state_nx = ST_LOAD;
          end else begin
            w_n_nx = r_n - 4'd1;
          end
        end else if (r_to == c_TO_LAST) begin
          w_err      = 1'b1;
          w_to_nx    = '0;
          w_state_nx = ST_IDLE;
        end else begin
          w_to_nx = r_to + 1'b1;
        end
      end
      ST_LOAD: begin
        w_state_nx = ST_IDLE;
        if (w_frame_ok) begin
          w_tick    = 1'b1;
          w_dout_nx = r_b[DATA_BITS:1];
        end else begin
          w_err = 1'b1;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // New byte is presented during the tick itself, then held in r_dout.
  assign bus.dout         = w_tick ? r_b[DATA_BITS:1] : r_dout;
  assign bus.rx_done_tick = w_tick;
  assign bus.rx_err       = w_err;

endmodule

`default_nettype wire

// File: tb/tb_ps2_rx_frame.sv
// ============================================================================
// Module : tb_ps2_rx_frame
// Brief  : Self-checking bench for ps2_rx_frame; frame-level reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ps2_rx_frame;
  import ps2_rx_frame_pkg::*;

  localparam int TB_FILTER_LEN  = 8;
  localparam int TB_TIMEOUT_CYC = 5000;
  localparam int HALF           = 2500;
  localparam int QUART          = 1250;
  localparam int LAT_PIN        = 2 + TB_FILTER_LEN + 2;

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  ps2_rx_frame_if bus();

  ps2_rx_frame #(
    .FILTER_LEN  (TB_FILTER_LEN),
    .TIMEOUT_CYC (TB_TIMEOUT_CYC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #10 clk = ~clk;

  ev_t        obs_q[$];
  ev_t        exp_q[$];
  int         cyc       = 0;
  int         last_fall = 0;
  int         n_assert  = 0;
  int         n_fail    = 0;
  logic [7:0] last_good = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    assert (!(bus.rx_done_tick === 1'b1 && bus.rx_err === 1'b1)) else begin
      n_fail++;
      $error("FAIL tick_err_overlap: observed both high at cycle %0d, expected at most one", cyc);
    end
    if (bus.rx_done_tick === 1'b1) obs_q.push_back('{1'b0, bus.dout, cyc});
    if (bus.rx_err === 1'b1)       obs_q.push_back('{1'b1, 8'h00, cyc});
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // Odd-parity bit for data, or its complement when a bad frame is wanted.
  function automatic bit par_bit(input logic [7:0] data, input bit good);
    bit even_ones;
    even_ones = ($countones(data) % 2) == 0;
    return good ? even_ones : !even_ones;
  endfunction

  function automatic void model(input logic [7:0] data, input bit par, input bit stop,
                                input bit en, input int nbits);
    bit par_ok;
    par_ok = ($countones({par, data}) % 2) == 1;
`ifndef PS2_PARITY_CHECK_EN
    par_ok = 1'b1;
`endif
    if (!en) return;
    if (nbits < 11 || !stop || !par_ok) begin
      exp_q.push_back('{1'b1, 8'h00, 0});
    end else begin
      exp_q.push_back('{1'b0, data, 0});
      last_good = data;
    end
  endfunction

  task automatic send_frame(input logic [7:0] data, input bit par, input bit stop, input int nbits);
    logic [10:0] f;
    f = {stop, par, data, 1'b0};
    @(negedge clk);
    #3;
    for (int i = 0; i < nbits; i++) begin
      bus.ps2d = f[i];
      #QUART;
      bus.ps2c  = 1'b0;
      last_fall = cyc;
      #HALF;
      bus.ps2c = 1'b1;
      #QUART;
    end
    bus.ps2d = 1'b1;
  endtask

  task automatic frame(input logic [7:0] data, input bit good, input bit stop,
                       input bit en, input int nbits);
    bit par;
    par = par_bit(data, good);
    model(data, par, stop, en, nbits);
    send_frame(data, par, stop, nbits);
  endtask

  task automatic settle(input string tag, input int lat, input int wait_cyc);
    ev_t o, e;
    repeat (wait_cyc) @(negedge clk);
    if (lat > 0)
      check({tag, "_latency"}, obs_q.size() > 0 ? obs_q[$].cyc - last_fall : -1, lat);
    check({tag, "_events"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_kind"}, {31'd0, o.err}, {31'd0, e.err});
      check({tag, "_data"}, {24'd0, o.data}, {24'd0, e.data});
    end
    obs_q.delete();
    exp_q.delete();
    check({tag, "_dout"}, {24'd0, bus.dout}, {24'd0, last_good});
  endtask

  initial begin
    logic [7:0] rd;
    bit         rgood, rstop;
    bus.ps2c  = 1'b1;
    bus.ps2d  = 1'b1;
    bus.rx_en = 1'b1;
    reset     = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_dout", {24'd0, bus.dout}, 32'h00);
    check("rst_tick", {31'd0, bus.rx_done_tick}, 32'd0);
    check("rst_err",  {31'd0, bus.rx_err}, 32'd0);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    // single good frame and its pin-to-tick latency
    frame(8'h45, 1'b1, 1'b1, 1'b1, 11);
    settle("t1", LAT_PIN, 300);

    // back-to-back frames
    frame(8'h45, 1'b1, 1'b1, 1'b1, 11);
    frame(8'hF0, 1'b1, 1'b1, 1'b1, 11);
    frame(8'h45, 1'b1, 1'b1, 1'b1, 11);
    settle("t2", LAT_PIN, 300);

    // bad parity: rejected only when the parity check is built in
    frame(8'hF0, 1'b0, 1'b1, 1'b1, 11);
    settle("t3", LAT_PIN, 300);

    // bad stop bit, then recovery
    frame(8'h45, 1'b1, 1'b0, 1'b1, 11);
    settle("t4_bad_stop", LAT_PIN, 300);
    frame(8'h45, 1'b1, 1'b1, 1'b1, 11);
    settle("t4_recover", LAT_PIN, 300);

    // truncated frame times out, then recovery
    frame(8'h45, 1'b1, 1'b1, 1'b1, 5);
    settle("t5_timeout", 2 + TB_FILTER_LEN + 1 + TB_TIMEOUT_CYC, TB_TIMEOUT_CYC + 300);
    frame(8'h45, 1'b1, 1'b1, 1'b1, 11);
    settle("t5_recover", LAT_PIN, 300);

    // receiver disabled for a whole frame
    bus.rx_en = 1'b0;
    frame(8'h3C, 1'b1, 1'b1, 1'b0, 11);
    settle("t6_disabled", 0, 300);
    bus.rx_en = 1'b1;

    // short low glitch with data low must not start a frame
    @(negedge clk);
    #3;
    bus.ps2d = 1'b0;
    bus.ps2c = 1'b0;
    #60;
    bus.ps2c = 1'b1;
    bus.ps2d = 1'b1;
    settle("t6_glitch", 0, 300);
    frame(8'h45, 1'b1, 1'b1, 1'b1, 11);
    settle("t6_after_glitch", LAT_PIN, 300);

    // reset mid-frame drops the partial frame and clears dout
    frame(8'hA7, 1'b1, 1'b1, 1'b0, 5);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset     = 1'b0;
    last_good = 8'h00;
    settle("t6_reset", 0, TB_TIMEOUT_CYC + 300);
    frame(8'h45, 1'b1, 1'b1, 1'b1, 11);
    settle("t6_after_reset", LAT_PIN, 300);

    // randomized frames
    for (int k = 0; k < 4; k++) begin
      rd    = 8'($urandom);
      rgood = $urandom_range(0, 3) != 0;
      rstop = $urandom_range(0, 4) != 0;
      frame(rd, rgood, rstop, 1'b1, 11);
      settle("rand", LAT_PIN, 300);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
